mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 203 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory-access pipeline stage sitting between the EX/MEM and MEM/WB registers.
// Non-memory instructions pass straight to the MEM/WB register with one cycle
// of latency. Aligned loads and stores enter ACCESS, which holds a request on
// the data-memory port until the memory acks it or MAX_WAIT cycles elapse.
// A misaligned memory op never reaches memory and is retired at once as a
// faulted result.
//
// Ports
//   clock, reset         : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  : EX/MEM handshake (in_ready only in IDLE)
//   mem_read, mem_to_reg, pc_to_reg, mem_write, reg_write : EX/MEM control
//   pc, instruction, alu_res, rs2, write_addr             : EX/MEM data
//   dmem_req, dmem_we, dmem_addr, dmem_wdata : request to data memory
//   dmem_ack, dmem_rdata                     : response from data memory
//   wb_*                 : MEM/WB register (wb_valid pulses, others hold)
//   misalign_err, timeout_err : one-cycle fault pulses, aligned with wb_valid
module mem_access_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_read,
    input  logic        mem_to_reg,
    input  logic        pc_to_reg,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic [31:0] alu_res,
    input  logic [31:0] rs2,
    input  logic [4:0]  write_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_write_addr,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_instruction,
    output logic        misalign_err,
    output logic        timeout_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state, state_next;
    logic [7:0]  wait_cnt;

    // Instruction captured for the duration of an ACCESS.
    logic [31:0] cap_pc, cap_instr, cap_alu, cap_rs2;
    logic [4:0]  cap_waddr;
    logic        cap_we, cap_load, cap_m2r, cap_p2r, cap_rw;

    // Per-cycle decisions made by the FSM.
    logic        direct_wb, misalign, start_acc, acc_done, acc_timeout;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next state and control
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        direct_wb   = 1'b0;
        misalign    = 1'b0;
        start_acc   = 1'b0;
        acc_done    = 1'b0;
        acc_timeout = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!(mem_read || mem_write)) begin
                        direct_wb = 1'b1;
                    end else if (alu_res[1:0] != 2'b00) begin
                        misalign = 1'b1;
                    end else begin
                        start_acc  = 1'b1;
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // An ack on the final allowed cycle still counts as success.
                if (dmem_ack) begin
                    acc_done   = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == LAST_WAIT) begin
                    acc_timeout = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // in_ready is gated by reset so the stage never advertises acceptance
    // while reset is held.
    assign in_ready = (state == IDLE) && reset;

    // Request outputs are only meaningful in ACCESS; zero them elsewhere.
    assign dmem_req   = (state == ACCESS);
    assign dmem_we    = dmem_req && cap_we;
    assign dmem_addr  = dmem_req ? cap_alu : 32'h0;
    assign dmem_wdata = dmem_req ? cap_rs2 : 32'h0;

    // ------------------------------------------------------------------
    // Wait counter: number of ACCESS cycles already spent without an ack.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 8'd0;
        end else if (start_acc || acc_done || acc_timeout) begin
            wait_cnt <= 8'd0;
        end else if (state == ACCESS) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cap_pc    <= 32'h0;
            cap_instr <= 32'h0;
            cap_alu   <= 32'h0;
            cap_rs2   <= 32'h0;
            cap_waddr <= 5'd0;
            cap_we    <= 1'b0;
            cap_load  <= 1'b0;
            cap_m2r   <= 1'b0;
            cap_p2r   <= 1'b0;
            cap_rw    <= 1'b0;
        end else if (start_acc) begin
            cap_pc    <= pc;
            cap_instr <= instruction;
            cap_alu   <= alu_res;
            cap_rs2   <= rs2;
            cap_waddr <= write_addr;
            cap_we    <= mem_write;
            // Read+write together is a store: no load data is returned.
            cap_load  <= mem_read && !mem_write;
            cap_m2r   <= mem_to_reg;
            cap_p2r   <= pc_to_reg;
            cap_rw    <= reg_write;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB register and fault pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_write_addr  <= 5'd0;
            wb_data        <= 32'h0;
            wb_pc          <= 32'h0;
            wb_instruction <= 32'h0;
            misalign_err   <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            wb_valid     <= direct_wb || misalign || acc_done || acc_timeout;
            misalign_err <= misalign;
            timeout_err  <= acc_timeout;
            if (direct_wb || misalign) begin
                // Retired straight from the EX/MEM inputs; never load data.
                wb_pc          <= pc;
                wb_instruction <= instruction;
                wb_write_addr  <= write_addr;
                wb_data        <= pc_to_reg ? pc + 32'd4 : alu_res;
                wb_reg_write   <= reg_write && (write_addr != 5'd0) && !misalign;
            end else if (acc_done || acc_timeout) begin
                wb_pc          <= cap_pc;
                wb_instruction <= cap_instr;
                wb_write_addr  <= cap_waddr;
                if (cap_p2r)
                    wb_data <= cap_pc + 32'd4;
                else if (acc_done && cap_m2r && cap_load)
                    wb_data <= dmem_rdata;
                else
                    wb_data <= cap_alu;
                wb_reg_write   <= cap_rw && (cap_waddr != 5'd0) && acc_done;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage (MAX_WAIT = 4).
module tb_mem_access_stage;

    logic        clock;
    logic        reset;
    logic        in_valid, in_ready;
    logic        mem_read, mem_to_reg, pc_to_reg, mem_write, reg_write;
    logic [31:0] pc, instruction, alu_res, rs2;
    logic [4:0]  write_addr;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_data, wb_pc, wb_instruction;
    logic        misalign_err, timeout_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_access_stage #(.MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_read(mem_read), .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg),
        .mem_write(mem_write), .reg_write(reg_write),
        .pc(pc), .instruction(instruction), .alu_res(alu_res), .rs2(rs2),
        .write_addr(write_addr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_write_addr(wb_write_addr), .wb_data(wb_data), .wb_pc(wb_pc),
        .wb_instruction(wb_instruction),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid    = 1'b0;
        mem_read    = 1'b0;
        mem_to_reg  = 1'b0;
        pc_to_reg   = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        pc          = 32'h0;
        instruction = 32'h0;
        alu_res     = 32'h0;
        rs2         = 32'h0;
        write_addr  = 5'd0;
        dmem_ack    = 1'b0;
        dmem_rdata  = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        step();
        step();
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (dmem_req !== 1'b0) $display("FAIL reset_dmem_req: got %b want 0", dmem_req); else pass_cnt++;
        total_cnt++; if ({wb_valid, wb_reg_write, misalign_err, timeout_err} !== 4'b0)
            $display("FAIL reset_flags: got %b want 0000", {wb_valid, wb_reg_write, misalign_err, timeout_err}); else pass_cnt++;
        total_cnt++; if (wb_data !== 32'h0) $display("FAIL reset_wb_data: got %h want 0", wb_data); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready); else pass_cnt++;
        step();
    endtask

    task automatic test_alu();
        in_valid = 1'b1; alu_res = 32'h10; reg_write = 1'b1; write_addr = 5'd3;
        pc = 32'h40; instruction = 32'h0000_0013;
        step();
        clear_inputs();
        total_cnt++; if (wb_valid !== 1'b1) $display("FAIL alu_wb_valid: got %b want 1", wb_valid); else pass_cnt++;
        total_cnt++; if (wb_data !== 32'h10) $display("FAIL alu_wb_data: got %h want 00000010", wb_data); else pass_cnt++;
        total_cnt++; if (wb_reg_write !== 1'b1) $display("FAIL alu_wb_reg_write: got %b want 1", wb_reg_write); else pass_cnt++;
        total_cnt++; if (wb_write_addr !== 5'd3) $display("FAIL alu_wb_addr: got %0d want 3", wb_write_addr); else pass_cnt++;
        total_cnt++; if (wb_pc !== 32'h40 || wb_instruction !== 32'h13)
            $display("FAIL alu_wb_pc_instr: got %h/%h want 00000040/00000013", wb_pc, wb_instruction); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1 || dmem_req !== 1'b0)
            $display("FAIL alu_ready_req: got %b/%b want 1/0", in_ready, dmem_req); else pass_cnt++;
        step();
        total_cnt++; if (wb_valid !== 1'b0) $display("FAIL alu_wb_pulse: got %b want 0", wb_valid); else pass_cnt++;
        total_cnt++; if (wb_data !== 32'h10) $display("FAIL alu_wb_hold: got %h want 00000010", wb_data); else pass_cnt++;
    endtask

    task automatic test_load();
        int req_cycles = 0;
        in_valid = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; alu_res = 32'h100;
        reg_write = 1'b1; write_addr = 5'd5; pc = 32'h80;
        step();
        clear_inputs();
        // Hold in_valid with a different op to show it is ignored while busy.
        in_valid = 1'b1; alu_res = 32'h777;
        for (int i = 0; i < 3; i++) begin
            if (dmem_req === 1'b1) req_cycles++;
            total_cnt++; if (dmem_addr !== 32'h100 || dmem_we !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL load_req_c%0d: addr %h we %b rdy %b want 00000100 0 0", i, dmem_addr, dmem_we, in_ready); else pass_cnt++;
            if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF; in_valid = 1'b0; end
            step();
        end
        dmem_ack = 1'b0;
        total_cnt++; if (req_cycles != 3) $display("FAIL load_req_cycles: got %0d want 3", req_cycles); else pass_cnt++;
        total_cnt++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF)
            $display("FAIL load_wb: valid %b data %h want 1 deadbeef", wb_valid, wb_data); else pass_cnt++;
        total_cnt++; if (wb_reg_write !== 1'b1 || wb_write_addr !== 5'd5 || wb_pc !== 32'h80)
            $display("FAIL load_wb_ctl: rw %b wa %0d pc %h want 1 5 00000080", wb_reg_write, wb_write_addr, wb_pc); else pass_cnt++;
        total_cnt++; if (dmem_req !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL load_done: req %b rdy %b want 0 1", dmem_req, in_ready); else pass_cnt++;
        step();
    endtask

    task automatic test_store();
        in_valid = 1'b1; mem_write = 1'b1; alu_res = 32'h20; rs2 = 32'h55; write_addr = 5'd6;
        step();
        clear_inputs();
        total_cnt++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h55 || dmem_addr !== 32'h20)
            $display("FAIL store_req: req %b we %b wd %h a %h want 1 1 00000055 00000020", dmem_req, dmem_we, dmem_wdata, dmem_addr); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL store_in_ready: got %b want 0", in_ready); else pass_cnt++;
        dmem_ack = 1'b1; dmem_rdata = 32'hAAAA5555;
        step();
        dmem_ack = 1'b0;
        total_cnt++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_data !== 32'h20)
            $display("FAIL store_wb: v %b rw %b d %h want 1 0 00000020", wb_valid, wb_reg_write, wb_data); else pass_cnt++;
        step();
    endtask

    task automatic test_read_write_both();
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1; mem_to_reg = 1'b1;
        alu_res = 32'h24; rs2 = 32'h77; reg_write = 1'b1; write_addr = 5'd9;
        step();
        clear_inputs();
        total_cnt++; if (dmem_we !== 1'b1 || dmem_wdata !== 32'h77)
            $display("FAIL rw_both_we: we %b wd %h want 1 00000077", dmem_we, dmem_wdata); else pass_cnt++;
        dmem_ack = 1'b1; dmem_rdata = 32'h1234;
        step();
        dmem_ack = 1'b0;
        total_cnt++; if (wb_valid !== 1'b1 || wb_data !== 32'h24)
            $display("FAIL rw_both_wb: v %b d %h want 1 00000024", wb_valid, wb_data); else pass_cnt++;
        step();
    endtask

    task automatic test_misalign();
        in_valid = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; alu_res = 32'h102;
        reg_write = 1'b1; write_addr = 5'd7;
        #1;
        total_cnt++; if (dmem_req !== 1'b0) $display("FAIL misalign_no_req_now: got %b want 0", dmem_req); else pass_cnt++;
        step();
        clear_inputs();
        total_cnt++; if (misalign_err !== 1'b1 || dmem_req !== 1'b0)
            $display("FAIL misalign_pulse: err %b req %b want 1 0", misalign_err, dmem_req); else pass_cnt++;
        total_cnt++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL misalign_wb: v %b rw %b rdy %b want 1 0 1", wb_valid, wb_reg_write, in_ready); else pass_cnt++;
        step();
        total_cnt++; if (misalign_err !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL misalign_one_cycle: err %b v %b want 0 0", misalign_err, wb_valid); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int budget = 0;
        in_valid = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; alu_res = 32'h200;
        reg_write = 1'b1; write_addr = 5'd8;
        step();
        clear_inputs();
        while (dmem_req === 1'b1 && budget < 20) begin
            req_cycles++;
            budget++;
            step();
        end
        total_cnt++; if (req_cycles != 4) $display("FAIL timeout_req_cycles: got %0d want 4", req_cycles); else pass_cnt++;
        total_cnt++; if (timeout_err !== 1'b1 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0)
            $display("FAIL timeout_pulse: err %b v %b rw %b want 1 1 0", timeout_err, wb_valid, wb_reg_write); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL timeout_idle: got %b want 1", in_ready); else pass_cnt++;
        step();
        total_cnt++; if (timeout_err !== 1'b0) $display("FAIL timeout_one_cycle: got %b want 0", timeout_err); else pass_cnt++;
    endtask

    task automatic test_reset_mid_access();
        in_valid = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; alu_res = 32'h300;
        reg_write = 1'b1; write_addr = 5'd4;
        step();
        clear_inputs();
        total_cnt++; if (dmem_req !== 1'b1) $display("FAIL rst_mid_enter: got %b want 1", dmem_req); else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        #1;
        total_cnt++; if (dmem_req !== 1'b0 || in_ready !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL rst_mid_async: req %b rdy %b v %b want 0 0 0", dmem_req, in_ready, wb_valid); else pass_cnt++;
        #2 reset = 1'b1;
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        step();
        dmem_ack = 1'b0;
        total_cnt++; if (wb_valid !== 1'b0 || wb_data !== 32'h0 || dmem_req !== 1'b0)
            $display("FAIL rst_late_ack: v %b d %h req %b want 0 00000000 0", wb_valid, wb_data, dmem_req); else pass_cnt++;
        step();
    endtask

    task automatic test_jal();
        in_valid = 1'b1; pc_to_reg = 1'b1; pc = 32'hFFFFFFFC; alu_res = 32'h999;
        reg_write = 1'b1; write_addr = 5'd1; instruction = 32'h0000_00EF;
        step();
        clear_inputs();
        total_cnt++; if (wb_valid !== 1'b1 || wb_data !== 32'h0 || wb_reg_write !== 1'b1)
            $display("FAIL jal_wb: v %b d %h rw %b want 1 00000000 1", wb_valid, wb_data, wb_reg_write); else pass_cnt++;
        total_cnt++; if (wb_pc !== 32'hFFFFFFFC || wb_instruction !== 32'hEF)
            $display("FAIL jal_pc_instr: %h/%h want fffffffc/000000ef", wb_pc, wb_instruction); else pass_cnt++;
        step();
    endtask

    task automatic test_x0_and_idle_ack();
        in_valid = 1'b1; alu_res = 32'h5; reg_write = 1'b1; write_addr = 5'd0;
        step();
        clear_inputs();
        total_cnt++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0)
            $display("FAIL x0_wb: v %b rw %b want 1 0", wb_valid, wb_reg_write); else pass_cnt++;
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        step();
        dmem_ack = 1'b0;
        total_cnt++; if (wb_valid !== 1'b0 || wb_data !== 32'h5 || dmem_req !== 1'b0)
            $display("FAIL idle_ack: v %b d %h req %b want 0 00000005 0", wb_valid, wb_data, dmem_req); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_read_write_both();
        test_misalign();
        test_timeout();
        test_reset_mid_access();
        test_jal();
        test_x0_and_idle_ack();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
